// File: rtl/sort_control.sv
// Sequencer for an in-place ascending bubble sort over a single-bus element datapath.
// Drives memory address, per-cycle bus strobes and a start/busy/done handshake.
module sort_control #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              greater_out,
  output logic [ADDR_W-1:0] address,
  output logic              memory_drive,
  output logic              memory_write,
  output logic              a_write,
  output logic              a_drive,
  output logic              b_write,
  output logic              b_drive,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pass_count
);

  typedef enum logic [3:0] {
    IDLE,
    PASS_START,
    READ_A,
    READ_B,
    COMPARE,
    SWAP_A,
    SWAP_B,
    ADVANCE,
    PASS_END,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_J = ADDR_W'(DEPTH - 2);

  state_t            state, state_next;
  logic [ADDR_W-1:0] p, p_next;
  logic [ADDR_W-1:0] j, j_next;
  logic              swapped, swapped_next;
  logic [ADDR_W-1:0] pass_count_next;
  logic [ADDR_W-1:0] j_plus_one;

  // j never exceeds DEPTH-2, so j+1 cannot wrap in ADDR_W bits
  assign j_plus_one = j + ADDR_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      p          <= '0;
      j          <= '0;
      swapped    <= 1'b0;
      pass_count <= '0;
    end else begin
      state      <= state_next;
      p          <= p_next;
      j          <= j_next;
      swapped    <= swapped_next;
      pass_count <= pass_count_next;
    end
  end

  always_comb begin
    state_next      = state;
    p_next          = p;
    j_next          = j;
    swapped_next    = swapped;
    pass_count_next = pass_count;
    address         = '0;
    memory_drive    = 1'b0;
    memory_write    = 1'b0;
    a_write         = 1'b0;
    a_drive         = 1'b0;
    b_write         = 1'b0;
    b_drive         = 1'b0;
    busy            = (state != IDLE);
    done            = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_next      = PASS_START;
          p_next          = '0;
          pass_count_next = '0;
        end
      end
      PASS_START: begin
        j_next       = '0;
        swapped_next = 1'b0;
        state_next   = READ_A;
      end
      READ_A: begin
        address      = j;
        memory_drive = 1'b1;
        a_write      = 1'b1;
        state_next   = READ_B;
      end
      READ_B: begin
        address      = j_plus_one;
        memory_drive = 1'b1;
        b_write      = 1'b1;
        state_next   = COMPARE;
      end
      COMPARE: begin
        // strict compare keeps equal elements in place
        state_next = greater_out ? SWAP_A : ADVANCE;
      end
      SWAP_A: begin
        address      = j;
        b_drive      = 1'b1;
        memory_write = 1'b1;
        swapped_next = 1'b1;
        state_next   = SWAP_B;
      end
      SWAP_B: begin
        address      = j_plus_one;
        a_drive      = 1'b1;
        memory_write = 1'b1;
        state_next   = ADVANCE;
      end
      ADVANCE: begin
        if (j == LAST_J - p) begin
          state_next = PASS_END;
        end else begin
          j_next     = j_plus_one;
          state_next = READ_A;
        end
      end
      PASS_END: begin
        pass_count_next = pass_count + ADDR_W'(1);
        if (!swapped || p == LAST_J) begin
          state_next = DONE;
        end else begin
          p_next     = p + ADDR_W'(1);
          state_next = PASS_START;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
